// File: rtl/id_stage_params.sv
// Shared types for the ID stage interfaces.
// ID reports taken branches/jumps back to IF on IDToIFBranchBusData.
// The taken flag is a one-cycle pulse per resolved branch.
package id_stage_params;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } IDToIFBranchBusData;

endpackage

// File: rtl/if_stage_params.sv
// Constants and the IF->ID bus type for the fetch stage.
// The vectors are the default fetch targets after reset and exceptions.
// EXC_CODE_ADEL is the code reported for misaligned fetch addresses.
package if_stage_params;

  localparam logic [31:0] IF_RESET_VECTOR     = 32'hBFC0_0000;
  localparam logic [31:0] IF_EXCEPTION_VECTOR = 32'hBFC0_0380;
  localparam logic [4:0]  EXC_CODE_ADEL       = 5'h04;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] instruction;
    logic        exception_valid;
    logic [4:0]  exception_code;
    logic        is_address_fault;
    logic [31:0] badvaddr_value;
  } IFToIDInstructionBusData;

endpackage

// File: rtl/wb_stage_params.sv
// Shared types for the WB stage interfaces.
// WB signals pipeline flushes: an exception redirect or an ERET return.
// Either bit set means every younger stage discards its contents.
package wb_stage_params;

  typedef struct packed {
    logic exception_valid;
    logic eret_flush;
  } WBExceptionBus;

endpackage

// File: rtl/if_stage.sv
// Purpose: MIPS instruction fetch - PC, SRAM request, branch/flush redirect, AdEL tagging.
// Latency: fetch issued in cycle N is presented to ID in cycle N+1.
// Backpressure: !id_allow_in holds PC/output and stops requests; SRAM data is buffered on stall.
module if_stage
  import if_stage_params::*;
  import id_stage_params::*;
  import wb_stage_params::*;
#(
  parameter logic [31:0] RESET_VECTOR     = IF_RESET_VECTOR,
  parameter logic [31:0] EXCEPTION_VECTOR = IF_EXCEPTION_VECTOR
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    id_allow_in,
  input  IDToIFBranchBusData      branch_bus,
  input  WBExceptionBus           wb_exception_bus,
  input  logic [31:0]             cp0_epc,
  output IFToIDInstructionBusData if_to_id_bus,
  output logic                    inst_sram_en,
  output logic [31:0]             inst_sram_addr,
  input  logic [31:0]             inst_sram_rdata
);

  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        fetched_q;

  logic        flush;
  logic        if_allow_in;
  logic        issue;
  logic        use_branch;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        misaligned;

  assign flush       = wb_exception_bus.exception_valid || wb_exception_bus.eret_flush;
  assign if_allow_in = !if_valid_q || id_allow_in;
  // A flush forces a fetch even while ID is stalled.
  assign issue       = reset_n && (flush || if_allow_in);
  // A valid IF entry while a branch is known is the delay slot; the fetch that
  // replaces it goes to the target. A same-cycle pulse is used directly so a
  // taken branch costs no bubble.
  assign use_branch  = if_valid_q && (pend_q || branch_bus.taken);
  assign br_target   = pend_q ? pend_tgt_q : branch_bus.target;
  assign misaligned  = |next_pc[1:0];

  assign inst_sram_en   = issue && !misaligned;
  assign inst_sram_addr = {next_pc[31:2], 2'b00};

  // Next-PC select: ERET over exception over branch over sequential.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (wb_exception_bus.eret_flush) begin
      next_pc = cp0_epc;
    end else if (wb_exception_bus.exception_valid) begin
      next_pc = EXCEPTION_VECTOR;
    end else if (use_branch) begin
      next_pc = br_target;
    end
  end

  // Entry, pending-branch and stall-buffer next state.
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;

    if (issue) begin
      pc_d       = next_pc;
      if_valid_d = 1'b1;
      fault_d    = misaligned;
    end

    // A flush drops any branch seen this cycle or earlier.
    if (flush) begin
      pend_d = 1'b0;
    end else if (issue && use_branch) begin
      pend_d = 1'b0;
    end else if (branch_bus.taken) begin
      pend_d     = 1'b1;
      pend_tgt_d = branch_bus.target;
    end

    // SRAM data is only on the bus the cycle after the request; hold it if ID stalls then.
    if (flush || issue) begin
      buf_vld_d = 1'b0;
    end else if (fetched_q && if_valid_q && !id_allow_in && !buf_vld_q) begin
      buf_vld_d = 1'b1;
      buf_d     = inst_sram_rdata;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q       <= RESET_VECTOR - 32'd4;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
      buf_q      <= 32'd0;
      buf_vld_q  <= 1'b0;
      fetched_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      fetched_q  <= inst_sram_en;
    end
  end

  // Output bus; a faulted entry carries no instruction word.
  always_comb begin
    if_to_id_bus                  = '0;
    if_to_id_bus.valid            = if_valid_q && !flush;
    if_to_id_bus.program_count    = pc_q;
    if_to_id_bus.exception_valid  = fault_q;
    if_to_id_bus.is_address_fault = fault_q;
    if (fault_q) begin
      if_to_id_bus.exception_code = EXC_CODE_ADEL;
      if_to_id_bus.badvaddr_value = pc_q;
    end else begin
      if_to_id_bus.instruction = buf_vld_q ? buf_q : inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall, branch, AdEL, flush, ERET.
// The SRAM model returns ~addr one cycle after a request and DEADBEEF otherwise.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_if_stage;
  import if_stage_params::*;
  import id_stage_params::*;
  import wb_stage_params::*;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    id_allow_in;
  IDToIFBranchBusData      branch_bus;
  WBExceptionBus           wb_exception_bus;
  logic [31:0]             cp0_epc;
  IFToIDInstructionBusData if_to_id_bus;
  logic                    inst_sram_en;
  logic [31:0]             inst_sram_addr;
  logic [31:0]             inst_sram_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  if_stage dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .id_allow_in      (id_allow_in),
    .branch_bus       (branch_bus),
    .wb_exception_bus (wb_exception_bus),
    .cp0_epc          (cp0_epc),
    .if_to_id_bus     (if_to_id_bus),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous SRAM model.
  always @(posedge clock) inst_sram_rdata <= inst_sram_en ? ~inst_sram_addr : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic rst, input logic alw, input logic tk, input logic [31:0] tgt,
                        input logic exc, input logic eret, input logic [31:0] epc);
    reset_n                          = rst;
    id_allow_in                      = alw;
    branch_bus.taken                 = tk;
    branch_bus.target                = tgt;
    wb_exception_bus.exception_valid = exc;
    wb_exception_bus.eret_flush      = eret;
    cp0_epc                          = epc;
    #1;
  endtask

  initial begin
    set_in(0, 1, 0, 0, 0, 0, 0);
    tick();
    // Reset state
    chk("rst_valid", 32'(if_to_id_bus.valid), 32'd0);
    chk("rst_en",    32'(inst_sram_en),       32'd0);
    chk("rst_pc",    if_to_id_bus.program_count, 32'hBFBF_FFFC);

    // C1: first fetch after release
    set_in(1, 1, 0, 0, 0, 0, 0);
    chk("c1_en",    32'(inst_sram_en),       32'd1);
    chk("c1_addr",  inst_sram_addr,          32'hBFC0_0000);
    chk("c1_valid", 32'(if_to_id_bus.valid), 32'd0);
    tick();
    // C2
    chk("c2_valid", 32'(if_to_id_bus.valid),   32'd1);
    chk("c2_pc",    if_to_id_bus.program_count, 32'hBFC0_0000);
    chk("c2_inst",  if_to_id_bus.instruction,   32'h403F_FFFF);
    chk("c2_addr",  inst_sram_addr,             32'hBFC0_0004);
    tick();
    // C3-C5: three stall cycles holding BFC00004
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("c3_en",   32'(inst_sram_en),          32'd0);
    chk("c3_pc",   if_to_id_bus.program_count, 32'hBFC0_0004);
    chk("c3_inst", if_to_id_bus.instruction,   32'h403F_FFFB);
    tick();
    chk("c4_en",   32'(inst_sram_en),          32'd0);
    chk("c4_inst", if_to_id_bus.instruction,   32'h403F_FFFB);
    tick();
    chk("c5_pc",   if_to_id_bus.program_count, 32'hBFC0_0004);
    chk("c5_inst", if_to_id_bus.instruction,   32'h403F_FFFB);
    tick();
    // C6: release; buffered word handed off, next fetch BFC00008
    set_in(1, 1, 0, 0, 0, 0, 0);
    chk("c6_valid", 32'(if_to_id_bus.valid),   32'd1);
    chk("c6_inst",  if_to_id_bus.instruction,  32'h403F_FFFB);
    chk("c6_en",    32'(inst_sram_en),         32'd1);
    chk("c6_addr",  inst_sram_addr,            32'hBFC0_0008);
    tick();
    // C7
    chk("c7_inst", if_to_id_bus.instruction, 32'h403F_FFF7);
    chk("c7_addr", inst_sram_addr,           32'hBFC0_000C);
    tick();
    // C8: branch at 08 taken, delay slot 0C in IF
    set_in(1, 1, 1, 32'hBFC0_0100, 0, 0, 0);
    chk("c8_inst", if_to_id_bus.instruction, 32'h403F_FFF3);
    chk("c8_addr", inst_sram_addr,           32'hBFC0_0100);
    tick();
    // C9
    set_in(1, 1, 0, 0, 0, 0, 0);
    chk("c9_pc",   if_to_id_bus.program_count, 32'hBFC0_0100);
    chk("c9_inst", if_to_id_bus.instruction,   32'h403F_FEFF);
    chk("c9_addr", inst_sram_addr,             32'hBFC0_0104);
    tick();
    // C10: branch to misaligned target
    set_in(1, 1, 1, 32'hBFC0_0102, 0, 0, 0);
    chk("c10_en", 32'(inst_sram_en), 32'd0);
    tick();
    // C11: AdEL entry, then stall on it
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("c11_valid", 32'(if_to_id_bus.valid),            32'd1);
    chk("c11_exc",   32'(if_to_id_bus.exception_valid),  32'd1);
    chk("c11_code",  32'(if_to_id_bus.exception_code),   32'h04);
    chk("c11_af",    32'(if_to_id_bus.is_address_fault), 32'd1);
    chk("c11_bad",   if_to_id_bus.badvaddr_value,        32'hBFC0_0102);
    chk("c11_inst",  if_to_id_bus.instruction,           32'd0);
    tick();
    // C12: branch captured while stalled
    set_in(1, 0, 1, 32'hBFC0_0200, 0, 0, 0);
    chk("c12_en", 32'(inst_sram_en), 32'd0);
    tick();
    // C13: exception mid-stall
    set_in(1, 0, 0, 0, 1, 0, 0);
    chk("c13_en",    32'(inst_sram_en),       32'd1);
    chk("c13_addr",  inst_sram_addr,          32'hBFC0_0380);
    chk("c13_valid", 32'(if_to_id_bus.valid), 32'd0);
    tick();
    // C14: pending branch must be gone
    set_in(1, 1, 0, 0, 0, 0, 0);
    chk("c14_valid", 32'(if_to_id_bus.valid),           32'd1);
    chk("c14_pc",    if_to_id_bus.program_count,        32'hBFC0_0380);
    chk("c14_inst",  if_to_id_bus.instruction,          32'h403F_FC7F);
    chk("c14_exc",   32'(if_to_id_bus.exception_valid), 32'd0);
    chk("c14_addr",  inst_sram_addr,                    32'hBFC0_0384);
    tick();
    // C15: ERET
    set_in(1, 1, 0, 0, 0, 1, 32'hBFC0_0040);
    chk("c15_en",    32'(inst_sram_en),       32'd1);
    chk("c15_addr",  inst_sram_addr,          32'hBFC0_0040);
    chk("c15_valid", 32'(if_to_id_bus.valid), 32'd0);
    tick();
    // C16
    set_in(1, 1, 0, 0, 0, 0, 32'hBFC0_0040);
    chk("c16_pc",   if_to_id_bus.program_count, 32'hBFC0_0040);
    chk("c16_inst", if_to_id_bus.instruction,   32'h403F_FFBF);
    chk("c16_addr", inst_sram_addr,             32'hBFC0_0044);
    tick();
    // C17: ERET and exception together, ERET wins
    set_in(1, 1, 0, 0, 1, 1, 32'hBFC0_0040);
    chk("c17_addr", inst_sram_addr, 32'hBFC0_0040);
    tick();
    // C18: stalled on the ERET target
    set_in(1, 0, 0, 0, 0, 0, 0);
    chk("c18_pc",   if_to_id_bus.program_count, 32'hBFC0_0040);
    chk("c18_inst", if_to_id_bus.instruction,   32'h403F_FFBF);
    tick();
    // C19: reset during stall with a flush pending
    set_in(0, 0, 0, 0, 1, 0, 0);
    chk("c19_en", 32'(inst_sram_en), 32'd0);
    tick();
    // C20: back in reset state
    chk("c20_valid", 32'(if_to_id_bus.valid),   32'd0);
    chk("c20_pc",    if_to_id_bus.program_count, 32'hBFBF_FFFC);
    chk("c20_en",    32'(inst_sram_en),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
